commutator_5to3_ctrl: RTL and testbench
=======================================

// Module: commutator_5to3_ctrl
// PURPOSE
//  Connection controller and registered switch for the 5-to-3 commutator.
//  - Allocates up to 3 output ports among 5 requesting input lines, using round-robin priority.
//  - Holds each connection until the input releases it.
//  - Registers the switched data, so each output stage behaves as a D-trigger bank.
//  - Sits directly upstream of the output D-trigger stage and feeds it select, valid and data.
// PARAMETERS
//  DATA_W          1   width of each input/output data lane
//  TIMEOUT_CYCLES  16  auto-release limit in cycles; used only with COMMUTATOR_TIMEOUT_EN
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         synchronous, active-high reset
//  req       in   5         req[i]=1: input i wants an output port
//  rel       in   5         rel[i]=1: input i releases its connection this cycle
//  data_in   in   5*DATA_W  lane i = data_in[i*DATA_W +: DATA_W]
//  grant     out  5         grant[i]=1: input i is connected to some output
//  out_valid out  3         out_valid[j]=1: output j is BUSY
//  out_sel   out  9         3 bits per output j: index (0..4) of the connected input
//  data_out  out  3*DATA_W  lane j = data_in lane out_sel[j], registered; 0 when not valid
// BEHAVIOUR
//  Reset
//  - rst is sampled at posedge clk.
//  - Outputs: grant=0, out_valid=0, out_sel=0, data_out=0.
//  - Internal: rr_ptr=0, all ports FREE, timeout counters=0.
//  - Reset mid-connection drops every connection on the same edge.
//  Per-port FSM
//  - States: FREE, BUSY.
//  - FREE->BUSY on allocation.
//  - BUSY->FREE when the owning input has rel=1 or req=0 (or on timeout, if compiled in).
//  Allocation, each edge
//  - Candidates are inputs i with req[i]=1, grant[i]=0 and rel[i]=0.
//  - Scan candidates in order rr_ptr, rr_ptr+1, ... modulo 5.
//  - Assign them to FREE ports in ascending index 0,1,2.
//  - Up to 3 grants per cycle; at most one port per input.
//  - rr_ptr moves to (last granted index + 1) mod 5; unchanged if nothing was granted.
//  Release/allocate collision
//  - A port freed on edge n is not re-allocated until edge n+1.
//  - rel and req both high with grant=0: rel wins, no grant.
//  Latency
//  - req seen at edge n gives grant, out_valid and out_sel at edge n.
//  - Data lags by one further edge: data_out on edge n+1 equals data_in sampled at edge n+1 from the
//    input selected at edge n.
//  - When out_valid[j]=0, lane j of data_out is forced to 0 on the next edge.
//  Other rules
//  - More than 3 candidates: the excess wait. No request is dropped and there is no error flag.
//  - Index arithmetic is mod 5; out_sel never takes a value above 4.
// CONFIGURATION
//  COMMUTATOR_TIMEOUT_EN defined
//  - Each BUSY port has a counter of width $clog2(TIMEOUT_CYCLES+1).
//  - Counter is 0 when the port is allocated and increments each cycle.
//  - At count TIMEOUT_CYCLES-1 the port goes FREE on the next edge and the owner's grant clears.
//  - The owner is re-eligible one edge later if req is still high; it re-enters round-robin order.
//  COMMUTATOR_TIMEOUT_EN undefined
//  - No counters; connections persist indefinitely.
// STRUCTURE
//  commutator_pkg
//  - Constants N_IN=5, N_OUT=3, SEL_W=3.
//  - typedef port_state_t {FREE, BUSY}.
//  - typedef sel_t logic [SEL_W-1:0].
//  commutator_rr_pick (sub-module)
//  - Combinational rotate-and-priority picker.
//  - Inputs: candidate mask, rr_ptr.
//  - Output: an ordered list of up to 3 winners.
//  - Instantiated once.
// TESTING
//  1 rst=1 for 2 cycles, req=5'b11111
//    -> grant=0, out_valid=0, data_out=0 throughout reset.
//  2 rst=0, req=5'b00101
//    -> after one edge: grant=00101, out_sel[0]=0, out_sel[1]=2, out_valid=011, rr_ptr=3.
//  3 req=11111 from idle, rr_ptr=3
//    -> grants inputs 3,4,0 on ports 0,1,2; inputs 1 and 2 wait.
//    -> Next: rel[4] pulses; port 1 goes FREE, then input 1 is granted one edge later.
//  4 port0 holds input 2 (DATA_W=1); toggle data_in[2] every cycle
//    -> data_out[0] follows it with a 1-edge lag.
//    -> Drop req[2]: out_valid[0]=0, then data_out[0]=0 on the next edge.
//  5 rel[1]=1 and req[1]=1 on the same edge with grant[1]=0
//    -> no grant that edge.
//    -> Freed port not reused on the release edge.
//  6 COMMUTATOR_TIMEOUT_EN, TIMEOUT_CYCLES=4, req[0] held high
//    -> grant[0] high for 4 cycles, low for 1 cycle, then re-granted.

Source files
------------

// File: rtl/commutator_pkg.sv
// Shared constants, types and index helper for the 5-to-3 commutator.
package commutator_pkg;

  localparam int unsigned N_IN  = 5;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    StFree = 1'b0,
    StBusy = 1'b1
  } port_state_t;

  // (base + offset) mod N_IN; both operands are expected to be in 0..N_IN-1.
  function automatic sel_t add_mod5(sel_t base, sel_t offset);
    logic [SEL_W:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= (SEL_W+1)'(N_IN)) begin
      sum = sum - (SEL_W+1)'(N_IN);
    end
    return sum[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/commutator_rr_pick.sv
// Combinational round-robin picker: rotates the candidate mask so scanning
// starts at rr_ptr, then emits up to N_OUT winners in scan order.
module commutator_rr_pick
  import commutator_pkg::*;
(
  input  logic [N_IN-1:0]  cand,
  input  sel_t             rr_ptr,
  output sel_t             win_idx [N_OUT],
  output logic [N_OUT-1:0] win_vld
);

  // Walk inputs rr_ptr, rr_ptr+1, ... mod N_IN and collect the first N_OUT candidates.
  always_comb begin
    logic [1:0] cnt;
    sel_t       idx;
    cnt     = '0;
    idx     = '0;
    win_vld = '0;
    for (int k = 0; k < N_OUT; k++) begin
      win_idx[k] = '0;
    end
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = add_mod5(rr_ptr, sel_t'(k));
      if (cand[idx] && (cnt < 2'(N_OUT))) begin
        win_idx[cnt] = idx;
        win_vld[cnt] = 1'b1;
        cnt          = cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/commutator_5to3_ctrl.sv
// Connection controller and registered switch for the 5-to-3 commutator.
// Each of the 3 output ports is a FREE/BUSY FSM owned by at most one input;
// free ports are handed out round-robin and held until the owner lets go.
// Switched data is registered one edge behind the select.
// Optional auto-release: define COMMUTATOR_TIMEOUT_EN to free a port after
// TIMEOUT_CYCLES cycles of ownership.
module commutator_5to3_ctrl
  import commutator_pkg::*;
#(
  parameter int unsigned DATA_W         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN-1:0]          rel,
  input  logic [N_IN*DATA_W-1:0]   data_in,
  output logic [N_IN-1:0]          grant,
  output logic [N_OUT-1:0]         out_valid,
  output logic [N_OUT*SEL_W-1:0]   out_sel,
  output logic [N_OUT*DATA_W-1:0]  data_out
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  port_state_t state_q [N_OUT];
  port_state_t state_d [N_OUT];
  sel_t        owner_q [N_OUT];
  sel_t        owner_d [N_OUT];
  sel_t        rr_q;
  sel_t        rr_d;

  logic [N_OUT*DATA_W-1:0] data_q;
  logic [N_OUT*DATA_W-1:0] data_d;

  logic [N_IN-1:0]  cand;
  logic [N_OUT-1:0] port_rel;
  logic [N_OUT-1:0] expired;
  sel_t             win_idx [N_OUT];
  logic [N_OUT-1:0] win_vld;

`ifdef COMMUTATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t cnt_q [N_OUT];
  cnt_t cnt_d [N_OUT];

  // A port expires on the cycle its ownership count reaches TIMEOUT_CYCLES-1.
  always_comb begin
    expired = '0;
    for (int j = 0; j < N_OUT; j++) begin
      expired[j] = (state_q[j] == StBusy) && (cnt_q[j] == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  // Count only while a port stays busy; allocation or release restarts at zero.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      if ((state_q[j] == StBusy) && (state_d[j] == StBusy)) begin
        cnt_d[j] = cnt_q[j] + CNT_W'(1);
      end else begin
        cnt_d[j] = '0;
      end
    end
  end

  // Ownership counters.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++) begin
      if (rst) begin
        cnt_q[j] <= '0;
      end else begin
        cnt_q[j] <= cnt_d[j];
      end
    end
  end
`else
  assign expired = '0;
`endif

  // A busy port drops when its owner releases, stops requesting, or times out.
  always_comb begin
    port_rel = '0;
    for (int j = 0; j < N_OUT; j++) begin
      port_rel[j] = (state_q[j] == StBusy) &&
                    (rel[owner_q[j]] || !req[owner_q[j]] || expired[j]);
    end
  end

  // Connected or releasing inputs are never candidates, so an input that
  // releases this edge can only come back one edge later.
  assign cand = req & ~grant & ~rel;

  commutator_rr_pick u_rr_pick (
    .cand    (cand),
    .rr_ptr  (rr_q),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Next-state: release busy ports, then fill ports that were already free
  // (in ascending order) with the picker's winners.
  always_comb begin
    logic [1:0] slot;
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    slot    = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (port_rel[j]) begin
        state_d[j] = StFree;
        owner_d[j] = '0;
      end else if ((state_q[j] == StFree) && (slot < 2'(N_OUT)) && win_vld[slot]) begin
        state_d[j] = StBusy;
        owner_d[j] = win_idx[slot];
        // Winners are in scan order, so the last one assigned sets the pointer.
        rr_d       = add_mod5(win_idx[slot], sel_t'(1));
        slot       = slot + 2'd1;
      end
    end
  end

  // Switch data through the connections that were live before this edge.
  always_comb begin
    data_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (state_q[j] == StBusy) begin
        for (int i = 0; i < N_IN; i++) begin
          if (owner_q[j] == sel_t'(i)) begin
            data_d[j*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Port state, owners, round-robin pointer and data lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) begin
        state_q[j] <= StFree;
        owner_q[j] <= '0;
      end
      rr_q   <= '0;
      data_q <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
      end
      rr_q   <= rr_d;
      data_q <= data_d;
    end
  end

  // Decode port state into grant / valid / select outputs.
  always_comb begin
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    for (int j = 0; j < N_OUT; j++) begin
      out_sel[j*SEL_W +: SEL_W] = owner_q[j];
      if (state_q[j] == StBusy) begin
        out_valid[j]      = 1'b1;
        grant[owner_q[j]] = 1'b1;
      end
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_commutator_5to3_ctrl.sv
// Directed self-checking bench for commutator_5to3_ctrl (DATA_W=1, TIMEOUT_CYCLES=4).
module tb_commutator_5to3_ctrl;

  localparam int unsigned DATA_W = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] rel;
  logic [4:0] data_in;
  logic [4:0] grant;
  logic [2:0] out_valid;
  logic [8:0] out_sel;
  logic [2:0] data_out;

  int checks = 0;
  int errors = 0;

  commutator_5to3_ctrl #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .data_in   (data_in),
    .grant     (grant),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] g, input logic [2:0] v,
                           input logic [8:0] s, input logic [2:0] d);
    check($sformatf("%s.grant", tag), 32'(grant), 32'(g));
    check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(v));
    check($sformatf("%s.out_sel", tag), 32'(out_sel), 32'(s));
    check($sformatf("%s.data_out", tag), 32'(data_out), 32'(d));
  endtask

  function automatic logic [8:0] sels(input int p2, input int p1, input int p0);
    return {p2[2:0], p1[2:0], p0[2:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] grant_pat;
    logic       v;
`ifdef COMMUTATOR_TIMEOUT_EN
    grant_pat = 6'b101111;
`else
    grant_pat = 6'b111111;
`endif

    // Reset held for two edges with every input requesting.
    rst = 1'b1; req = 5'b11111; rel = 5'b00000; data_in = 5'b00000;
    step(); check_all("rst_e1", 5'b00000, 3'b000, 9'd0, 3'b000);
    step(); check_all("rst_e2", 5'b00000, 3'b000, 9'd0, 3'b000);

    // Inputs 0 and 2 land on ports 0 and 1; pointer moves to 3.
    rst = 1'b0; req = 5'b00101;
    step(); check_all("alloc_0_2", 5'b00101, 3'b011, sels(0, 2, 0), 3'b000);

    req = 5'b00000;
    step(); check_all("idle_a", 5'b00000, 3'b000, 9'd0, 3'b000);

    // All request from pointer 3: inputs 3,4,0 win; pointer moves to 1.
    req = 5'b11111;
    step(); check_all("fill_340", 5'b11001, 3'b111, sels(0, 4, 3), 3'b000);

    // Input 4 releases; port 1 frees but is not reused on the same edge.
    rel = 5'b10000;
    step(); check_all("rel4", 5'b01001, 3'b101, sels(0, 0, 3), 3'b000);

    // Next edge input 1 (pointer 1) takes port 1; pointer moves to 2.
    rel = 5'b00000;
    step(); check_all("regrant1", 5'b01011, 3'b111, sels(0, 1, 3), 3'b000);

    req = 5'b00000;
    step(); check_all("idle_b", 5'b00000, 3'b000, 9'd0, 3'b000);

    // Input 2 alone takes port 0; pointer moves to 3.
    req = 5'b00100;
    step(); check_all("alloc2", 5'b00100, 3'b001, sels(0, 0, 2), 3'b000);

    // Lane 0 tracks data_in[2]; other lanes carry the opposite value as decoys.
    for (int k = 0; k < 6; k++) begin
      v       = k[0];
      data_in = v ? 5'b00100 : 5'b11011;
      step(); check($sformatf("data_follow%0d", k), 32'(data_out), {29'd0, 2'b00, v});
    end

    // Dropping req frees the port now; the data lane clears one edge later.
    req = 5'b00000; data_in = 5'b00100;
    step(); check_all("drop2", 5'b00000, 3'b000, 9'd0, 3'b001);
    step(); check("drop2_data_zero", 32'(data_out), 32'd0);

    // rel and req together on an unconnected input: rel wins.
    req = 5'b00010; rel = 5'b00010;
    step(); check_all("rel_beats_req", 5'b00000, 3'b000, 9'd0, 3'b000);
    rel = 5'b00000;
    step(); check_all("grant1", 5'b00010, 3'b001, sels(0, 0, 1), 3'b000);

    // Pointer 2: inputs 2,3 fill ports 1,2; pointer moves to 4.
    req = 5'b11111;
    step(); check_all("fill_23", 5'b01110, 3'b111, sels(3, 2, 1), 3'b000);

    // Input 1 releases port 0; waiting inputs do not get it this edge.
    rel = 5'b00010;
    step(); check_all("rel1_no_reuse", 5'b01100, 3'b110, sels(3, 2, 0), 3'b010);

    // Pointer 4: input 4 beats 0 and 1 for port 0; pointer moves to 0.
    rel = 5'b00000;
    step(); check_all("rr_wrap4", 5'b11100, 3'b111, sels(3, 2, 4), 3'b010);

    req = 5'b00000; data_in = 5'b00000;
    step(); check_all("idle_c", 5'b00000, 3'b000, 9'd0, 3'b000);

    // Long hold of input 0: persists, or drops for one cycle with timeout built in.
    req = 5'b00001;
    for (int k = 0; k < 6; k++) begin
      step(); check($sformatf("hold_grant%0d", k), 32'(grant), {27'd0, 4'b0000, grant_pat[k]});
    end

    // Pointer 1: inputs 1,2 take ports 1,2; port 0 keeps input 0.
    req = 5'b11111; data_in = 5'b11111;
    step(); check_all("fill_12", 5'b00111, 3'b111, sels(2, 1, 0), 3'b001);
    step(); check("all_lanes_data", 32'(data_out), 32'h7);

    // Reset mid-connection drops everything on the same edge.
    rst = 1'b1;
    step(); check_all("rst_mid", 5'b00000, 3'b000, 9'd0, 3'b000);

    // Pointer is back at 0 after reset.
    rst = 1'b0;
    step(); check_all("post_rst", 5'b00111, 3'b111, sels(2, 1, 0), 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
